int_sequencer: RTL and testbench

- CPU-side responder to the PIC interrupt handshake: samples interrupt/intVect and returns a one-cycle intAck.
- On an accepted interrupt: pushes PC and flags onto the data stack, acknowledges, clears global interrupt enable, redirects PC to the vector.
- Also executes RETI: pops flags and PC, then re-enables interrupts.
- Sits in the CPU core between control unit, register file and data-memory port; stalls the core via busy.

---
 rtl/int_sequencer_if.sv | 24 ++
 rtl/int_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_int_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_sequencer_if.sv
// PIC handshake and data-memory port of the interrupt sequencer.
// master: the sequencer side; slave: the PIC / memory side.
interface int_sequencer_if #(
    parameter int SP_WIDTH = 16
);
    logic                interrupt;
    logic [15:0]         intVect;
    logic                intAck;
    logic [SP_WIDTH-1:0] mem_addr;
    logic [7:0]          mem_dout;
    logic [7:0]          mem_din;
    logic                mem_w_en;
    logic                mem_r_en;

    modport master (
        input  interrupt, intVect, mem_din,
        output intAck, mem_addr, mem_dout, mem_w_en, mem_r_en
    );

    modport slave (
        output interrupt, intVect, mem_din,
        input  intAck, mem_addr, mem_dout, mem_w_en, mem_r_en
    );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt entry / RETI sequencer.
// Pushes PC and flags to the data stack on an accepted interrupt, acks the
// PIC and jumps to the vector; on RETI pops flags and PC and re-enables ie.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   IDLE     | waiting for an instruction boundary
//   PUSH_H   | write PC high byte to mem[S]
//   PUSH_L   | write PC low byte to mem[S-1]
//   PUSH_F   | write flags to mem[S-2]
//   ACK      | ack PIC, load PC=vector, SP=S-3, clear ie
//   POP_F    | read mem[S+1] (flags)
//   POP_L    | read mem[S+2] (PC low), capture flags
//   POP_H    | read mem[S+3] (PC high), capture PC low
//   RET_DONE | load PC/flags, SP=S+3, set ie
module int_sequencer #(
    parameter int SP_WIDTH    = 16,
    parameter int FLAGS_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    int_sequencer_if.master        bus,
    input  logic                   boundary,
    input  logic                   reti,
    input  logic                   ei,
    input  logic                   di,
    input  logic [15:0]            pc_in,
    input  logic [FLAGS_WIDTH-1:0] flags_in,
    input  logic [SP_WIDTH-1:0]    sp_in,
    output logic [15:0]            pc_out,
    output logic                   pc_load,
    output logic [FLAGS_WIDTH-1:0] flags_out,
    output logic                   flags_load,
    output logic [SP_WIDTH-1:0]    sp_out,
    output logic                   sp_load,
    output logic                   ie,
    output logic                   busy
);

    typedef enum logic [3:0] {
        IDLE,
        PUSH_H,
        PUSH_L,
        PUSH_F,
        ACK,
        POP_F,
        POP_L,
        POP_H,
        RET_DONE
    } state_t;

    state_t state, state_nx;

    logic [15:0]            pc_q;
    logic [15:0]            vect_q;
    logic [FLAGS_WIDTH-1:0] flags_q;
    logic [SP_WIDTH-1:0]    sp_q;
    logic [7:0]             pcl_q;
    logic [FLAGS_WIDTH-1:0] rflags_q;

    logic start_reti;
    logic start_int;
    logic start;

    // RETI wins over a simultaneous interrupt request at the same boundary.
    assign start_reti = (state == IDLE) && boundary && reti;
    assign start_int  = (state == IDLE) && boundary && !reti && bus.interrupt && ie;
    assign start      = start_reti || start_int;

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and strobe/data decode; outputs are zero outside their strobe cycle.
    always_comb begin
        state_nx     = state;
        bus.intAck   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_dout = '0;
        bus.mem_w_en = 1'b0;
        bus.mem_r_en = 1'b0;
        pc_out       = '0;
        pc_load      = 1'b0;
        flags_out    = '0;
        flags_load   = 1'b0;
        sp_out       = '0;
        sp_load      = 1'b0;
        busy         = (state != IDLE) || start;

        case (state)
            IDLE: begin
                if (start_reti) begin
                    state_nx = POP_F;
                end else if (start_int) begin
                    state_nx = PUSH_H;
                end
            end
            PUSH_H: begin
                bus.mem_w_en = 1'b1;
                bus.mem_addr = sp_q;
                bus.mem_dout = pc_q[15:8];
                state_nx     = PUSH_L;
            end
            PUSH_L: begin
                bus.mem_w_en = 1'b1;
                bus.mem_addr = sp_q - SP_WIDTH'(1);
                bus.mem_dout = pc_q[7:0];
                state_nx     = PUSH_F;
            end
            PUSH_F: begin
                bus.mem_w_en = 1'b1;
                bus.mem_addr = sp_q - SP_WIDTH'(2);
                bus.mem_dout = 8'(flags_q);
                state_nx     = ACK;
            end
            ACK: begin
                bus.intAck = 1'b1;
                pc_load    = 1'b1;
                pc_out     = vect_q;
                sp_load    = 1'b1;
                sp_out     = sp_q - SP_WIDTH'(3);
                state_nx   = IDLE;
            end
            POP_F: begin
                bus.mem_r_en = 1'b1;
                bus.mem_addr = sp_q + SP_WIDTH'(1);
                state_nx     = POP_L;
            end
            POP_L: begin
                bus.mem_r_en = 1'b1;
                bus.mem_addr = sp_q + SP_WIDTH'(2);
                state_nx     = POP_H;
            end
            POP_H: begin
                bus.mem_r_en = 1'b1;
                bus.mem_addr = sp_q + SP_WIDTH'(3);
                state_nx     = RET_DONE;
            end
            RET_DONE: begin
                // PC high byte arrives this cycle and is forwarded directly.
                pc_out     = {bus.mem_din, pcl_q};
                pc_load    = 1'b1;
                flags_out  = rflags_q;
                flags_load = 1'b1;
                sp_load    = 1'b1;
                sp_out     = sp_q + SP_WIDTH'(3);
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Latch the CPU context at start and collect popped bytes during RETI.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            vect_q   <= '0;
            flags_q  <= '0;
            sp_q     <= '0;
            pcl_q    <= '0;
            rflags_q <= '0;
        end else begin
            if (start) begin
                pc_q    <= pc_in;
                vect_q  <= bus.intVect;
                flags_q <= flags_in;
                sp_q    <= sp_in;
            end
            if (state == POP_L) begin
                rflags_q <= bus.mem_din[FLAGS_WIDTH-1:0];
            end
            if (state == POP_H) begin
                pcl_q <= bus.mem_din;
            end
        end
    end

    // Global interrupt enable; ei/di only honoured while fully idle, di dominant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie <= 1'b0;
        end else if (state == ACK) begin
            ie <= 1'b0;
        end else if (state == RET_DONE) begin
            ie <= 1'b1;
        end else if ((state == IDLE) && !start) begin
            if (di) begin
                ie <= 1'b0;
            end else if (ei) begin
                ie <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;

    logic        clk;
    logic        reset;
    logic        boundary, reti, ei, di;
    logic [15:0] pc_in;
    logic [7:0]  flags_in;
    logic [15:0] sp_in;
    logic [15:0] pc_out;
    logic        pc_load;
    logic [7:0]  flags_out;
    logic        flags_load;
    logic [15:0] sp_out;
    logic        sp_load;
    logic        ie;
    logic        busy;

    int_sequencer_if #(.SP_WIDTH(16)) bus ();

    int_sequencer #(.SP_WIDTH(16), .FLAGS_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.master),
        .boundary   (boundary),
        .reti       (reti),
        .ei         (ei),
        .di         (di),
        .pc_in      (pc_in),
        .flags_in   (flags_in),
        .sp_in      (sp_in),
        .pc_out     (pc_out),
        .pc_load    (pc_load),
        .flags_out  (flags_out),
        .flags_load (flags_load),
        .sp_out     (sp_out),
        .sp_load    (sp_load),
        .ie         (ie),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory seen by the DUT.
    logic [7:0] mem   [0:65535];
    // Memory contents as the model believes they should be.
    logic [7:0] mem_m [0:65535];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]   = 8'h00;
            mem_m[i] = 8'h00;
        end
        bus.mem_din = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.mem_w_en) mem[bus.mem_addr] <= bus.mem_dout;
        if (bus.mem_r_en) bus.mem_din <= mem[bus.mem_addr];
    end

    // Expected per-cycle output record; ie_op: 0 none, 1 clear after, 2 set after.
    typedef struct {
        logic        w;
        logic        r;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        ack;
        logic        pcl;
        logic [15:0] pc;
        logic        fl;
        logic [7:0]  flags;
        logic        spl;
        logic [15:0] sp;
        int          ie_op;
    } exp_t;

    exp_t q[$];
    logic ie_m = 1'b0;

    function automatic exp_t blank();
        exp_t e;
        e.w = 0; e.r = 0; e.addr = 0; e.dout = 0; e.ack = 0; e.pcl = 0; e.pc = 0;
        e.fl = 0; e.flags = 0; e.spl = 0; e.sp = 0; e.ie_op = 0;
        return e;
    endfunction

    // Model: cycle-by-cycle expected outputs built from the sequence rules.
    always @(negedge clk) begin
        exp_t e;
        logic idle_m, go, busy_exp;
        logic [15:0] s;
        if (!reset) begin
            q.delete();
            ie_m = 1'b0;
        end
        idle_m   = (q.size() == 0);
        busy_exp = !idle_m || (boundary && (reti || (bus.interrupt && ie_m)));
        go       = reset && idle_m && busy_exp;
        e        = idle_m ? blank() : q[0];

        chk("mem_w_en",   bus.mem_w_en, e.w);
        chk("mem_r_en",   bus.mem_r_en, e.r);
        chk("mem_addr",   bus.mem_addr, e.addr);
        chk("mem_dout",   bus.mem_dout, e.dout);
        chk("intAck",     bus.intAck,   e.ack);
        chk("pc_load",    pc_load,      e.pcl);
        chk("pc_out",     pc_out,       e.pc);
        chk("flags_load", flags_load,   e.fl);
        chk("flags_out",  flags_out,    e.flags);
        chk("sp_load",    sp_load,      e.spl);
        chk("sp_out",     sp_out,       e.sp);
        chk("ie",         ie,           ie_m);
        chk("busy",       busy,         busy_exp);

        if (reset) begin
            if (!idle_m) begin
                if (e.w) mem_m[e.addr] = e.dout;
                if (e.ie_op == 1) ie_m = 1'b0;
                if (e.ie_op == 2) ie_m = 1'b1;
                void'(q.pop_front());
            end else if (go) begin
                s = sp_in;
                if (reti) begin
                    e = blank(); e.r = 1; e.addr = s + 16'd1; q.push_back(e);
                    e = blank(); e.r = 1; e.addr = s + 16'd2; q.push_back(e);
                    e = blank(); e.r = 1; e.addr = s + 16'd3; q.push_back(e);
                    e = blank();
                    e.pcl = 1; e.pc = {mem_m[s + 16'd3], mem_m[s + 16'd2]};
                    e.fl = 1;  e.flags = mem_m[s + 16'd1];
                    e.spl = 1; e.sp = s + 16'd3; e.ie_op = 2;
                    q.push_back(e);
                end else begin
                    e = blank(); e.w = 1; e.addr = s;          e.dout = pc_in[15:8]; q.push_back(e);
                    e = blank(); e.w = 1; e.addr = s - 16'd1;  e.dout = pc_in[7:0];  q.push_back(e);
                    e = blank(); e.w = 1; e.addr = s - 16'd2;  e.dout = flags_in;    q.push_back(e);
                    e = blank();
                    e.ack = 1; e.pcl = 1; e.pc = bus.intVect;
                    e.spl = 1; e.sp = s - 16'd3; e.ie_op = 1;
                    q.push_back(e);
                end
            end else if (di) begin
                ie_m = 1'b0;
            end else if (ei) begin
                ie_m = 1'b1;
            end
        end
    end

    // Capture of last loads and ack count for the literal checks.
    int          ack_cnt = 0;
    int          pcl_cnt = 0;
    logic [15:0] last_pc = 0;
    logic [15:0] last_sp = 0;
    logic [7:0]  last_flags = 0;

    always @(negedge clk) begin
        if (bus.intAck) ack_cnt++;
        if (pc_load) begin
            pcl_cnt++;
            last_pc = pc_out;
        end
        if (sp_load) last_sp = sp_out;
        if (flags_load) last_flags = flags_out;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int ack0, pcl0;
        reset = 1'b0;
        boundary = 0; reti = 0; ei = 0; di = 0;
        pc_in = 0; flags_in = 0; sp_in = 0;
        bus.interrupt = 0; bus.intVect = 0;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("rst_ie", ie, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pc_load", pc_load, 1'b0);

        // Basic interrupt entry.
        ei = 1; tick(1); ei = 0;
        pc_in = 16'h1234; flags_in = 8'hA5; sp_in = 16'h00FF; bus.intVect = 16'h0400;
        bus.interrupt = 1; boundary = 1;
        tick(1);
        boundary = 0; bus.interrupt = 0;
        tick(5);
        chk("push_hi",  mem[16'h00FF], 8'h12);
        chk("push_lo",  mem[16'h00FE], 8'h34);
        chk("push_fl",  mem[16'h00FD], 8'hA5);
        chk("ack_pc",   last_pc, 16'h0400);
        chk("ack_sp",   last_sp, 16'h00FC);
        chk("ack_ie",   ie, 1'b0);
        chk("ack_cnt1", ack_cnt, 1);

        // RETI from that frame.
        reti = 1; boundary = 1; sp_in = 16'h00FC;
        tick(1);
        reti = 0; boundary = 0;
        tick(5);
        chk("reti_pc",    last_pc, 16'h1234);
        chk("reti_flags", last_flags, 8'hA5);
        chk("reti_sp",    last_sp, 16'h00FF);
        chk("reti_ie",    ie, 1'b1);

        // Held interrupt with ie=0, ei/di handling.
        di = 1; tick(1); di = 0;
        pc_in = 16'hABCD; flags_in = 8'h3C; sp_in = 16'h2000; bus.intVect = 16'h0800;
        bus.interrupt = 1; boundary = 1;
        tick(3);
        chk("held_busy", busy, 1'b0);
        chk("held_cnt", ack_cnt, 1);
        boundary = 0;
        ei = 1; di = 1; tick(1); ei = 0; di = 0;
        chk("eidi_ie", ie, 1'b0);
        ei = 1; tick(1); ei = 0;
        chk("ei_ie", ie, 1'b1);
        boundary = 1; tick(1); boundary = 0;
        tick(5);
        bus.interrupt = 0;
        chk("held_cnt2", ack_cnt, 2);
        chk("held_pc", last_pc, 16'h0800);

        // Stack wrap-around.
        ei = 1; tick(1); ei = 0;
        pc_in = 16'h5678; flags_in = 8'h0F; sp_in = 16'h0001; bus.intVect = 16'h0900;
        bus.interrupt = 1; boundary = 1;
        tick(1);
        boundary = 0; bus.interrupt = 0;
        tick(5);
        chk("wrap_m1",   mem[16'h0001], 8'h56);
        chk("wrap_m0",   mem[16'h0000], 8'h78);
        chk("wrap_mf",   mem[16'hFFFF], 8'h0F);
        chk("wrap_sp",   last_sp, 16'hFFFE);
        reti = 1; boundary = 1; sp_in = 16'hFFFE;
        tick(1);
        reti = 0; boundary = 0;
        tick(5);
        chk("unwrap_sp", last_sp, 16'h0001);
        chk("unwrap_pc", last_pc, 16'h5678);
        chk("unwrap_fl", last_flags, 8'h0F);

        // RETI and interrupt together: RETI first, then exactly one interrupt.
        ack0 = ack_cnt;
        reti = 1; bus.interrupt = 1; boundary = 1;
        sp_in = 16'h0001; pc_in = 16'h1111; flags_in = 8'h22; bus.intVect = 16'h0A00;
        tick(1);
        reti = 0; sp_in = 16'h3000;
        tick(12);
        boundary = 0; bus.interrupt = 0;
        tick(2);
        chk("both_acks", ack_cnt, ack0 + 1);
        chk("both_pc",   last_pc, 16'h0A00);
        chk("both_sp",   last_sp, 16'h2FFD);

        // Reset in the middle of a push.
        ei = 1; tick(1); ei = 0;
        pc_in = 16'h4321; flags_in = 8'h77; sp_in = 16'h4000; bus.intVect = 16'h0B00;
        bus.interrupt = 1; boundary = 1;
        ack0 = ack_cnt; pcl0 = pcl_cnt;
        tick(1);
        boundary = 0;
        tick(1);
        #1 reset = 1'b0;
        #1;
        chk("abort_w_en",  bus.mem_w_en, 1'b0);
        chk("abort_ack",   bus.intAck, 1'b0);
        chk("abort_pcl",   pc_load, 1'b0);
        chk("abort_addr",  bus.mem_addr, 16'h0000);
        tick(2);
        reset = 1'b1;
        boundary = 1;
        tick(6);
        boundary = 0; bus.interrupt = 0;
        tick(1);
        chk("abort_ie",    ie, 1'b0);
        chk("abort_acks",  ack_cnt, ack0);
        chk("abort_loads", pcl_cnt, pcl0);
        chk("abort_m",     mem[16'h4000], 8'h43);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
